// File: rtl/flop_arbiter_pkg.sv
// Shared types and helpers for the flop arbiter slice: width defaults, beat
// layout, output-stage state encoding and the source-index width function.
package flop_arbiter_pkg;

    localparam int FA_ADDR_W = 32;
    localparam int FA_DATA_W = 32;

    typedef struct packed {
        logic [FA_ADDR_W-1:0] addr;
        logic [FA_DATA_W-1:0] data;
    } beat_t;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    function automatic int src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/flop_arbiter_ctrl_if.sv
// Requester/consumer bundle of the flop arbiter. req_lock exists only when
// ARB_LOCK_EN is defined.
interface flop_arbiter_ctrl_if
    import flop_arbiter_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int ADDR_W = FA_ADDR_W,
    parameter int DATA_W = FA_DATA_W
);
    localparam int IDX_W = src_w(NREQ);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
`ifdef ARB_LOCK_EN
    logic [NREQ-1:0]        req_lock;
`endif
    logic                   out_valid;
    logic                   out_ready;
    logic [ADDR_W-1:0]      addr_o;
    logic [DATA_W-1:0]      data_o;
    logic [IDX_W-1:0]       out_src;

    modport master (
        output req_valid, req_addr, req_data,
`ifdef ARB_LOCK_EN
        output req_lock,
`endif
        output out_ready,
        input  req_ready, out_valid, addr_o, data_o, out_src
    );

    modport slave (
        input  req_valid, req_addr, req_data,
`ifdef ARB_LOCK_EN
        input  req_lock,
`endif
        input  out_ready,
        output req_ready, out_valid, addr_o, data_o, out_src
    );

endinterface

// File: rtl/flop_arbiter_rr_pick.sv
// Rotate-priority picker: first set bit of req at or above ptr, wrapping to 0.
// Purely combinational; returns one-hot grant, its index and an any flag.
module flop_arbiter_rr_pick
    import flop_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = src_w(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan NREQ positions starting at ptr; first hit wins.
    always_comb begin
        logic [IDX_W:0]   sum_s;
        logic [IDX_W-1:0] pos_s;
        grant = {NREQ{1'b0}};
        idx   = {IDX_W{1'b0}};
        any   = 1'b0;
        sum_s = {(IDX_W+1){1'b0}};
        pos_s = {IDX_W{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            sum_s = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum_s >= (IDX_W+1)'(NREQ)) begin
                sum_s = sum_s - (IDX_W+1)'(NREQ);
            end else begin
                sum_s = sum_s;
            end
            pos_s = sum_s[IDX_W-1:0];
            if (!any && req[pos_s]) begin
                any          = 1'b1;
                idx          = pos_s;
                grant[pos_s] = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/flop_arbiter_ctrl.sv
// Round-robin arbiter feeding one registered addr/data output stage.
// Optional grant locking is compiled in with ARB_LOCK_EN.
module flop_arbiter_ctrl
    import flop_arbiter_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int ADDR_W = FA_ADDR_W,
    parameter int DATA_W = FA_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    flop_arbiter_ctrl_if.slave  bus
);
    localparam int IDX_W = src_w(NREQ);

    out_state_e        state_r;
    out_state_e        state_nxt_s;
    logic [IDX_W-1:0]  ptr_r;
    logic [IDX_W-1:0]  ptr_nxt_s;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic [IDX_W-1:0]  src_r;
    logic [NREQ-1:0]   req_mask_s;
    logic [NREQ-1:0]   grant_s;
    logic [IDX_W-1:0]  gidx_s;
    logic              gany_s;
    logic              can_load_s;
    logic              accept_s;
    logic              lock_take_s;

    assign can_load_s = (state_r == ST_EMPTY) | bus.out_ready;
    assign accept_s   = can_load_s & gany_s;

`ifdef ARB_LOCK_EN
    logic             lock_r;
    logic [IDX_W-1:0] lock_idx_r;

    // While locked only the holder stays eligible, even if it idles.
    assign req_mask_s  = lock_r ? ({{(NREQ-1){1'b0}}, 1'b1} << lock_idx_r) : {NREQ{1'b1}};
    assign lock_take_s = accept_s & bus.req_lock[gidx_s];

    // Lock owner is re-evaluated on every accepted beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_r     <= 1'b0;
            lock_idx_r <= {IDX_W{1'b0}};
        end else if (accept_s) begin
            lock_r     <= lock_take_s;
            lock_idx_r <= gidx_s;
        end
    end
`else
    assign req_mask_s  = {NREQ{1'b1}};
    assign lock_take_s = 1'b0;
`endif

    flop_arbiter_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (bus.req_valid & req_mask_s),
        .ptr   (ptr_r),
        .grant (grant_s),
        .idx   (gidx_s),
        .any   (gany_s)
    );

    assign bus.req_ready = accept_s ? grant_s : {NREQ{1'b0}};
    assign bus.out_valid = (state_r == ST_FULL);
    assign bus.addr_o    = addr_r;
    assign bus.data_o    = data_r;
    assign bus.out_src   = src_r;

    // Output-stage occupancy and round-robin pointer advance.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        case (state_r)
            ST_EMPTY: state_nxt_s = accept_s ? ST_FULL : ST_EMPTY;
            ST_FULL: begin
                if (bus.out_ready) begin
                    state_nxt_s = accept_s ? ST_FULL : ST_EMPTY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: state_nxt_s = ST_EMPTY;
        endcase
        if (accept_s && !lock_take_s) begin
            if (gidx_s == IDX_W'(NREQ - 1)) begin
                ptr_nxt_s = {IDX_W{1'b0}};
            end else begin
                ptr_nxt_s = gidx_s + {{(IDX_W-1){1'b0}}, 1'b1};
            end
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // State and pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_EMPTY;
            ptr_r   <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
        end
    end

    // Output payload register; holds while nothing is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r <= {ADDR_W{1'b0}};
            data_r <= {DATA_W{1'b0}};
            src_r  <= {IDX_W{1'b0}};
        end else if (accept_s) begin
            addr_r <= bus.req_addr[gidx_s*ADDR_W +: ADDR_W];
            data_r <= bus.req_data[gidx_s*DATA_W +: DATA_W];
            src_r  <= gidx_s;
        end
    end

endmodule

// File: tb/tb_flop_arbiter_ctrl.sv
// Scoreboard bench for flop_arbiter_ctrl: a reference model predicts grants,
// queues the expected beats and compares them as the consumer takes them.
module tb_flop_arbiter_ctrl;
    import flop_arbiter_pkg::*;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int IW   = src_w(NREQ);

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [IW-1:0] s;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    flop_arbiter_ctrl_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();

    flop_arbiter_ctrl #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t          sb_q[$];
    int            total = 0;
    int            bad   = 0;
    int            exp_ptr;
    bit            exp_full;
    bit            exp_lock;
    int            exp_lock_idx;
    int            last_g;
    bit            last_acc;
    logic [AW-1:0] addr_v [NREQ];
    logic [DW-1:0] data_v [NREQ];
    logic          lock_v [NREQ];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (p + k) % NREQ;
            if (((v >> j) & 1) != 0) return j;
        end
        return -1;
    endfunction

    task automatic model_clear();
        sb_q.delete();
        exp_ptr      = 0;
        exp_full     = 1'b0;
        exp_lock     = 1'b0;
        exp_lock_idx = 0;
    endtask

    // One clock: drive payloads, check at negedge, advance model, return at posedge+1.
    task automatic step();
        logic [NREQ-1:0] mv;
        logic [NREQ-1:0] exp_rdy;
        int              g;
        bit              acc;
        bit              lk;
        exp_t            e;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*AW +: AW] = addr_v[i];
            bus.req_data[i*DW +: DW] = data_v[i];
`ifdef ARB_LOCK_EN
            bus.req_lock[i] = lock_v[i];
`endif
        end
        @(negedge clk);
        mv = bus.req_valid;
        if (exp_lock) mv = mv & (NREQ'(1) << exp_lock_idx);
        g       = ref_pick(mv, exp_ptr);
        acc     = (!exp_full || bus.out_ready) && (g >= 0);
        exp_rdy = acc ? (NREQ'(1) << g) : '0;
        check_val("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        check_val("out_valid", 64'(bus.out_valid), 64'(exp_full));
        if (exp_full && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                check_val("sb_underflow", 64'(sb_q.size()), 64'd1);
            end else begin
                e = sb_q.pop_front();
                check_val("addr_o", 64'(bus.addr_o), 64'(e.a));
                check_val("data_o", 64'(bus.data_o), 64'(e.d));
                check_val("out_src", 64'(bus.out_src), 64'(e.s));
            end
        end
        lk = 1'b0;
        if (acc) begin
            sb_q.push_back('{a: addr_v[g], d: data_v[g], s: IW'(g)});
`ifdef ARB_LOCK_EN
            lk = lock_v[g];
`endif
            exp_lock     = lk;
            exp_lock_idx = g;
            if (!lk) exp_ptr = (g + 1) % NREQ;
        end
        exp_full = acc || (exp_full && !bus.out_ready);
        last_g   = g;
        last_acc = acc;
        @(posedge clk);
        #1;
        if (acc) begin
            addr_v[g] = addr_v[g] + 32'h10;
            data_v[g] = data_v[g] + 32'h1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_clear();
    endtask

    initial begin
        logic [AW-1:0] held_a;
        logic [DW-1:0] held_d;
        logic [AW-1:0] next_a;
        int            n2;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
`ifdef ARB_LOCK_EN
        bus.req_lock  = '0;
`endif
        for (int i = 0; i < NREQ; i++) begin
            addr_v[i] = {8'(i + 1), 24'h000000};
            data_v[i] = 32'hD000_0000 | 32'(i);
            lock_v[i] = 1'b0;
        end
        model_clear();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_addr_o", 64'(bus.addr_o), 64'd0);
        check_val("rst_data_o", 64'(bus.data_o), 64'd0);
        check_val("rst_out_src", 64'(bus.out_src), 64'd0);
        rst = 1'b1;

        // Single requester
        addr_v[1] = 32'h100;
        data_v[1] = 32'hA5;
        bus.req_valid = 4'b0010;
        bus.out_ready = 1'b1;
        step();
        check_val("single_valid", 64'(bus.out_valid), 64'd1);
        check_val("single_addr", 64'(bus.addr_o), 64'h100);
        check_val("single_data", 64'(bus.data_o), 64'hA5);
        check_val("single_src", 64'(bus.out_src), 64'd1);
        bus.req_valid = 4'b0000;
        step();

        // All valid, full throughput from pointer 0
        do_reset();
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            check_val("rr_seq", 64'(bus.out_src), 64'(k % NREQ));
        end

        // Backpressure: beat held, nothing accepted, then back-to-back reload
        do_reset();
        bus.req_valid = 4'b0001;
        step();
        held_a = bus.addr_o;
        held_d = bus.data_o;
        check_val("bp_loaded", 64'(held_a), 64'(sb_q[0].a));
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b0011;
        next_a = addr_v[1];
        for (int k = 0; k < 5; k++) begin
            step();
            check_val("bp_addr_hold", 64'(bus.addr_o), 64'(held_a));
            check_val("bp_data_hold", 64'(bus.data_o), 64'(held_d));
        end
        bus.out_ready = 1'b1;
        step();
        check_val("bp_reload", 64'(bus.addr_o), 64'(next_a));
        bus.req_valid = 4'b0000;
        step();

        // Wrap from pointer 3 to 0
        do_reset();
        bus.req_valid = 4'b0100;
        step();
        bus.req_valid = 4'b1001;
        step();
        check_val("wrap_src3", 64'(bus.out_src), 64'd3);
        step();
        check_val("wrap_src0", 64'(bus.out_src), 64'd0);

        // Asynchronous reset with a beat in the register
        bus.req_valid = 4'b0000;
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("arst_addr_o", 64'(bus.addr_o), 64'd0);
        check_val("arst_data_o", 64'(bus.data_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_clear();
        bus.req_valid = 4'b1111;
        step();
        check_val("ptr_after_rst", 64'(bus.out_src), 64'd0);

`ifdef ARB_LOCK_EN
        // Requester 2 locks for two beats, releases on the third
        do_reset();
        bus.req_valid = 4'b1111;
        n2 = 0;
        for (int c = 0; c < 7; c++) begin
            lock_v[2] = (n2 < 2);
            step();
            if (last_acc && last_g == 2) n2++;
        end
        lock_v[2] = 1'b0;
        check_val("lock_beats", 64'(n2), 64'd3);
`else
        n2 = 0;
`endif

        // Random traffic
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bus.req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            bus.out_ready = ($urandom_range(0, 9) < 7);
`ifdef ARB_LOCK_EN
            for (int i = 0; i < NREQ; i++) lock_v[i] = ($urandom_range(0, 4) == 0);
`endif
            step();
        end

        // Drain
        bus.req_valid = 4'b0000;
        bus.out_ready = 1'b1;
        repeat (3) step();
        check_val("drain", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
